stream_register_pipe: RTL
=========================

STREAM_REGISTER_PIPE -- requirements
Module: stream_register_pipe

Interface
REQ-001 Parameters SHALL be:
- T, default logic, payload type.
- NUM_STAGES, default 2, register stages; legal range 1..16.
- CUT_READY, default 1'b0; 1 inserts a one-entry input skid buffer so ready_o is driven from a flop.
REQ-002 Ports SHALL be:
- clk_i  in  1  single clock; all state updates on the rising edge.
- rst_i  in  1  reset; synchronous, active-high.
- clr_i  in  1  synchronous flush.
- valid_i  in  1  input valid.
- ready_o  out  1  input ready.
- data_i  in  T  input payload.
- valid_o  out  1  output valid.
- ready_i  in  1  output ready.
- data_o  out  T  output payload.
- count_o  out  $clog2(NUM_STAGES+2)  items currently held.

Function
REQ-003 Input handshake SHALL occur when valid_i & ready_o; output handshake SHALL occur when valid_o & ready_i.
REQ-004 Stages SHALL be a chain S[0]..S[NUM_STAGES-1], each holding one valid bit and one payload register; S[NUM_STAGES-1] SHALL drive valid_o/data_o.
REQ-005 Stage k SHALL be ready when ~v[k] | rdy[k+1], with rdy[NUM_STAGES] = ready_i; bubbles SHALL collapse in the same cycle.
REQ-006 Stage k SHALL load its payload only when its upstream is valid and it is ready; the payload SHALL hold otherwise.
REQ-007 Sustained throughput SHALL be one item per cycle with valid_i=ready_i=1.
REQ-008 Empty-pipe latency from input handshake to valid_o SHALL be exactly NUM_STAGES cycles; the skid buffer SHALL add no latency when empty.
REQ-009 Items SHALL exit in acceptance order with no loss or duplication; capacity SHALL be NUM_STAGES + CUT_READY.
REQ-010 With CUT_READY=0, ready_o SHALL equal rdy[0], a combinational function of ready_i and stage valids.
REQ-011 With CUT_READY=1, ready_o SHALL equal ~skid_valid, a flop output.
REQ-012 With CUT_READY=1, an accepted item SHALL enter S[0] directly if rdy[0]; otherwise it SHALL enter the skid buffer.
REQ-013 With CUT_READY=1, while skid_valid is set, S[0] SHALL load from the skid buffer ahead of data_i, and skid_valid SHALL clear on that load.
REQ-014 With CUT_READY=0, data_i/valid_i SHALL have no path to the skid buffer; the buffer SHALL not exist.
REQ-015 count_o SHALL equal the number of valid stages plus skid_valid.
REQ-016 count_o SHALL be unchanged on a cycle with simultaneous input and output handshakes.
REQ-017 While clr_i=1, ready_o and valid_o SHALL be forced to 0 combinationally, so no handshakes occur.
REQ-018 On the clock edge with clr_i=1, all valid bits and skid_valid SHALL clear, and all payload registers SHALL load '0.
REQ-019 A full pipe with ready_i=0 SHALL hold all data stable, with valid_o=1 and ready_o=0.

Reset
REQ-020 While rst_i=1 at a rising edge, all stage valid bits and skid_valid SHALL be 0, and payloads SHALL be '0.
REQ-021 After reset, valid_o=0, data_o='0 and count_o=0; ready_o=1 unless clr_i=1.
REQ-022 Reset SHALL take priority over clr_i and all handshakes; items in flight at reset SHALL be discarded.

Configuration
REQ-023 Macro STREAM_REGISTER_PIPE_OCC_EN SHALL control the occupancy counter.
REQ-024 With STREAM_REGISTER_PIPE_OCC_EN defined, count_o SHALL behave per REQ-015/016.
REQ-025 Without STREAM_REGISTER_PIPE_OCC_EN, count_o SHALL be tied to 0, no counter logic SHALL be synthesised, and all other behaviour SHALL be identical.

Verification
REQ-026 NUM_STAGES=3, CUT_READY=0, single item 0xA5 at cycle 0, ready_i=1 -> valid_o=1, data_o=0xA5 at cycle 3, for exactly one cycle.
REQ-027 NUM_STAGES=2, stream 0..99 with valid_i=ready_i=1 -> 100 outputs in order on consecutive cycles; with OCC_EN, count_o=2 in steady state.
REQ-028 NUM_STAGES=2, CUT_READY=1, ready_i=0, drive 4 items -> 3 accepted, ready_o=0, count_o=3, data_o=item0; ready_i=1 -> items 0,1,2 in order, and ready_o returns 1 the cycle after the skid drains.
REQ-029 Random valid_i/ready_i (50%) for 10k items, all parameter combos -> scoreboard match; ready_o never changes within a cycle when CUT_READY=1.
REQ-030 Full pipe, pulse clr_i for one cycle -> ready_o=valid_o=0 that cycle; count_o=0 and data_o=0 next cycle, with no item emitted.
REQ-031 rst_i asserted mid-stream for one cycle -> valid_o=0 and count_o=0 next cycle; the first post-reset item appears after NUM_STAGES cycles.

Source files
------------

// File: rtl/stream_register_pipe.sv
`default_nettype none
// ============================================================================
// Module   : stream_register_pipe
// Brief    : Valid/ready register pipeline with collapsing bubbles and an
//            optional one-entry input skid buffer (CUT_READY). The occupancy
//            counter on count_o exists only when STREAM_REGISTER_PIPE_OCC_EN
//            is defined; otherwise count_o is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module stream_register_pipe #(
    parameter type T          = logic,
    parameter int  NUM_STAGES = 2,
    parameter bit  CUT_READY  = 1'b0
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              clr_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  T                                  data_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output T                                  data_o,
    output logic [$clog2(NUM_STAGES+2)-1:0]   count_o
);

    logic                r_valid    [NUM_STAGES];
    T                    r_data     [NUM_STAGES];
    logic                w_up_valid [NUM_STAGES];
    T                    w_up_data  [NUM_STAGES];
    logic [NUM_STAGES:0] w_rdy;
    logic                w_in_hs;
    logic                w_s0_valid;
    T                    w_s0_data;

    // A stage accepts when empty or when its occupant moves on this cycle,
    // so the ready chain is resolved from the output end backwards.
    always_comb begin
        w_rdy[NUM_STAGES] = ready_i;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            w_rdy[k] = ~r_valid[k] | w_rdy[k+1];
        end
    end

    generate
        for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_up_valid[k] = w_s0_valid;
                assign w_up_data[k]  = w_s0_data;
            end else begin : g_body
                assign w_up_valid[k] = r_valid[k-1];
                assign w_up_data[k]  = r_data[k-1];
            end

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                end else if (w_rdy[k]) begin
                    r_valid[k] <= w_up_valid[k];
                    if (w_up_valid[k]) begin
                        r_data[k] <= w_up_data[k];
                    end
                end
            end
        end
    endgenerate

    assign valid_o = r_valid[NUM_STAGES-1] & ~clr_i;
    assign data_o  = r_data[NUM_STAGES-1];

    generate
        if (CUT_READY) begin : g_skid
            logic r_skid_valid;
            T     r_skid_data;

            assign ready_o    = ~r_skid_valid & ~clr_i;
            assign w_in_hs    = valid_i & ready_o;
            // A parked item always has priority into the first stage.
            assign w_s0_valid = r_skid_valid | w_in_hs;
            assign w_s0_data  = r_skid_valid ? r_skid_data : data_i;

            always_ff @(posedge clk_i) begin
                if (rst_i || clr_i) begin
                    r_skid_valid <= 1'b0;
                    r_skid_data  <= '0;
                end else if (r_skid_valid) begin
                    if (w_rdy[0]) begin
                        r_skid_valid <= 1'b0;
                    end
                end else if (w_in_hs && !w_rdy[0]) begin
                    r_skid_valid <= 1'b1;
                    r_skid_data  <= data_i;
                end
            end
        end else begin : g_no_skid
            assign ready_o    = w_rdy[0] & ~clr_i;
            assign w_in_hs    = valid_i & ready_o;
            assign w_s0_valid = w_in_hs;
            assign w_s0_data  = data_i;
        end
    endgenerate

`ifdef STREAM_REGISTER_PIPE_OCC_EN
    localparam int C_CNT_W = $clog2(NUM_STAGES + 2);

    logic [C_CNT_W-1:0] r_count;
    logic               w_out_hs;

    assign w_out_hs = valid_o & ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            r_count <= '0;
        end else if (w_in_hs && !w_out_hs) begin
            r_count <= r_count + 1'b1;
        end else if (!w_in_hs && w_out_hs) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign count_o = r_count;
`else
    assign count_o = '0;
`endif

endmodule
`default_nettype wire
